// File: rtl/xbar_rr_if.sv
// Purpose: request/flit/grant bundle between the input VC buffers, the crossbar and the output link registers.
// Latency: wires only; grt is combinational in the crossbar, output fields are registered there.
// Backpressure: ordy is per-output credit availability; grt is the per-input accept back to the VC buffers.
// Ports (slave = crossbar side):
//   req/port/idata/ivalid/ivch/itail : per-input request and flit, input i in slice i
//   ordy                             : per-output downstream ready
//   grt                              : slice i bit j = input i granted output j
//   odata/ovalid/ovch/otail          : per-output registered flit, output j in slice j
interface xbar_rr_if #(
  parameter int NPORT = 5,
  parameter int DATAW = 64,
  parameter int VCHW  = 2
);
  localparam int PORTW = $clog2(NPORT);

  logic [NPORT-1:0]       req;
  logic [NPORT*PORTW-1:0] port;
  logic [NPORT*DATAW-1:0] idata;
  logic [NPORT-1:0]       ivalid;
  logic [NPORT*VCHW-1:0]  ivch;
  logic [NPORT-1:0]       itail;
  logic [NPORT-1:0]       ordy;
  logic [NPORT*NPORT-1:0] grt;
  logic [NPORT*DATAW-1:0] odata;
  logic [NPORT-1:0]       ovalid;
  logic [NPORT*VCHW-1:0]  ovch;
  logic [NPORT-1:0]       otail;

  modport slave (
    input  req, port, idata, ivalid, ivch, itail, ordy,
    output grt, odata, ovalid, ovch, otail
  );

  modport master (
    output req, port, idata, ivalid, ivch, itail, ordy,
    input  grt, odata, ovalid, ovch, otail
  );
endinterface

// File: rtl/xbar_rr.sv
// Purpose: NPORT x NPORT crossbar, per-output round-robin arbiter with head-to-tail (wormhole) locking.
// Latency: grant is combinational (0 cycles); flit appears on the output register 1 cycle after transfer.
// Backpressure: ordy[j]=0 suppresses any grant to output j; ungranted flits stay upstream.
// Ports: clk, rst_ (synchronous, active-high); bus (xbar_rr_if.slave) carries all request, flit and grant fields.
module xbar_rr #(
  parameter int NPORT = 5,
  parameter int DATAW = 64,
  parameter int VCHW  = 2
) (
  input  logic     clk,
  input  logic     rst_,
  xbar_rr_if.slave bus
);
  localparam int PORTW = $clog2(NPORT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Per-input views of the flattened buses.
  logic [PORTW-1:0] port_s  [NPORT];
  logic [DATAW-1:0] idata_s [NPORT];
  logic [VCHW-1:0]  ivch_s  [NPORT];

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
    assign port_s[gi]  = bus.port[gi*PORTW +: PORTW];
    assign idata_s[gi] = bus.idata[gi*DATAW +: DATAW];
    assign ivch_s[gi]  = bus.ivch[gi*VCHW +: VCHW];
  end

  state_t           state_q [NPORT];
  state_t           state_d [NPORT];
  logic [PORTW-1:0] own_q   [NPORT];
  logic [PORTW-1:0] own_d   [NPORT];
  logic [PORTW-1:0] ptr_q   [NPORT];
  logic [PORTW-1:0] ptr_d   [NPORT];
  logic [PORTW-1:0] sel     [NPORT];  // input feeding output j this cycle
  logic [NPORT-1:0] cand    [NPORT];  // cand[j][i]: input i requests output j
  logic [NPORT-1:0] gcol    [NPORT];  // gcol[j][i]: input i granted output j
  logic [NPORT-1:0] xfer;

  logic [DATAW-1:0] odata_q [NPORT];
  logic [VCHW-1:0]  ovch_q  [NPORT];
  logic [NPORT-1:0] ovalid_q;
  logic [NPORT-1:0] otail_q;

  // Out-of-range destinations never equal a legal j, so they simply never become candidates.
  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      cand[j] = '0;
      for (int i = 0; i < NPORT; i++) begin
        cand[j][i] = bus.req[i] && (port_s[i] == PORTW'(j));
      end
    end
  end

  // Per-output arbiter FSM: next state, owner, pointer and grant column.
  always_comb begin
    logic             found;
    logic [PORTW-1:0] win;
    logic [PORTW:0]   sum;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    xfer  = '0;
    for (int j = 0; j < NPORT; j++) begin
      state_d[j] = state_q[j];
      own_d[j]   = own_q[j];
      ptr_d[j]   = ptr_q[j];
      sel[j]     = own_q[j];
      gcol[j]    = '0;

      // First candidate at or after ptr, wrapping modulo NPORT.
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NPORT; k++) begin
        sum = {1'b0, ptr_q[j]} + (PORTW+1)'(k);
        if (sum >= (PORTW+1)'(NPORT)) begin
          sum = sum - (PORTW+1)'(NPORT);
        end
        if (!found && cand[j][sum[PORTW-1:0]]) begin
          found = 1'b1;
          win   = sum[PORTW-1:0];
        end
      end

      if (state_q[j] == IDLE) begin
        if (bus.ordy[j] && found) begin
          gcol[j][win] = 1'b1;
          sel[j]       = win;
          ptr_d[j]     = (win == PORTW'(NPORT - 1)) ? '0 : win + 1'b1;
          // A single-flit packet moving now needs no lock; anything else
          // (including a grant the winner did not use) locks the output.
          if (!(bus.ivalid[win] && bus.itail[win])) begin
            state_d[j] = BUSY;
            own_d[j]   = win;
          end
        end
      end else begin
        // Locked: only the owner may move, and only with downstream credit.
        if (bus.req[own_q[j]] && bus.ordy[j]) begin
          gcol[j][own_q[j]] = 1'b1;
          if (bus.ivalid[own_q[j]] && bus.itail[own_q[j]]) begin
            state_d[j] = IDLE;
          end
        end
      end

      xfer[j] = |(gcol[j] & bus.ivalid);
    end
  end

  // Grants are withheld for the whole time reset is asserted.
  always_comb begin
    bus.grt = '0;
    for (int i = 0; i < NPORT; i++) begin
      for (int j = 0; j < NPORT; j++) begin
        bus.grt[i*NPORT + j] = gcol[j][i] & ~rst_;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NPORT; j++) begin
      if (rst_) begin
        state_q[j] <= IDLE;
        own_q[j]   <= '0;
        ptr_q[j]   <= '0;
      end else begin
        state_q[j] <= state_d[j];
        own_q[j]   <= own_d[j];
        ptr_q[j]   <= ptr_d[j];
      end
    end
  end

  // Output link registers: fields hold between transfers, valid pulses per flit.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NPORT; j++) begin
      if (rst_) begin
        ovalid_q[j] <= 1'b0;
        otail_q[j]  <= 1'b0;
        odata_q[j]  <= '0;
        ovch_q[j]   <= '0;
      end else begin
        ovalid_q[j] <= xfer[j];
        if (xfer[j]) begin
          odata_q[j] <= idata_s[sel[j]];
          ovch_q[j]  <= ivch_s[sel[j]];
          otail_q[j] <= bus.itail[sel[j]];
        end
      end
    end
  end

  for (genvar gj = 0; gj < NPORT; gj++) begin : g_pack
    assign bus.odata[gj*DATAW +: DATAW] = odata_q[gj];
    assign bus.ovch[gj*VCHW +: VCHW]    = ovch_q[gj];
  end
  assign bus.ovalid = ovalid_q;
  assign bus.otail  = otail_q;
endmodule

// File: doc/xbar_rr.md
# xbar_rr

Parametrised NPORT×NPORT router crossbar with a per-output round-robin arbiter, wormhole packet locking and per-output downstream-ready gating. It sits between the input VC buffers and the output link registers. It is the next generation of the fixed 5-port crossbar: any port count and width, fair arbitration, grants held from head to tail flit, and registered outputs.

## Interface
- NPORT, 5, number of input ports and number of output ports (≥2)
- DATAW, 64, flit data width in bits
- VCHW, 2, virtual-channel id width in bits
- PORTW, $clog2(NPORT), destination-port field width (derived; not overridden)
- clk  in  1  rising-edge clock
- rst_  in  1  reset, synchronous, active-high (single clock domain)
- req  in  NPORT  req[i]: input i requests output port[i]
- port  in  NPORT*PORTW  destination of input i in slice i
- idata  in  NPORT*DATAW  flit of input i
- ivalid  in  NPORT  flit of input i present this cycle
- ivch  in  NPORT*VCHW  VC id of input i's flit
- itail  in  NPORT  flit of input i is a packet's last flit (a head flit may also be the tail)
- ordy  in  NPORT  ordy[j]: output j may accept a flit this cycle (credit available)
- grt  out  NPORT*NPORT  slice i bit j: input i is granted output j (combinational)
- odata  out  NPORT*DATAW  registered flit on output j
- ovalid  out  NPORT  registered valid on output j
- ovch  out  NPORT*VCHW  registered VC id on output j
- otail  out  NPORT  registered tail on output j

## Operation
- Each output j has an FSM with states IDLE and BUSY, an owner register own_j (PORTW bits) and a round-robin pointer ptr_j (PORTW bits).
- An input i is a candidate for output j when req[i]=1 and port[i]==j. Requests with port[i] ≥ NPORT are ignored: no grant is issued and no error is raised.
- IDLE, ordy[j]=1 and at least one candidate: the winner w is the first candidate scanning i = ptr_j, ptr_j+1, …, wrapping modulo NPORT. grt[w][j]=1 in the same cycle, and ptr_j ← (w+1) mod NPORT at the clock edge.
  - If a transfer occurs that cycle with itail[w]=1, the FSM stays IDLE.
  - Otherwise it goes to BUSY with own_j ← w. This includes the case where the winner raises no ivalid: the grant locks the output anyway.
- IDLE with ordy[j]=0: no grant is issued, and ptr_j and the state hold.
- BUSY: grt[own_j][j] = req[own_j] & ordy[j]. No other input is granted output j. On a transfer with itail=1 the FSM returns to IDLE, and the next arbitration happens the following cycle.
- Transfer on output j: grt[i][j] & ivalid[i]. ivalid without a grant is ignored, and the flit stays in the upstream buffer.
- An input targets exactly one output, so each grt slice has at most one bit set. Different outputs operate fully in parallel.
- Datapath: on a transfer, odata_j/ovch_j/otail_j ← input i's fields and ovalid_j ← 1. With no transfer, ovalid_j ← 0 and odata_j/ovch_j/otail_j hold their last values.
- If the owner drops req mid-packet, the lock is kept and output j stalls until the owner sends its tail.

## Timing
- Grant latency is 0 cycles: combinational from req, port, ordy and state. Data latency is 1 cycle: a flit transferred in cycle t appears on the output in cycle t+1.
- Reset (rst_=1 at a rising edge) applies the following; on the cycle after reset deasserts, arbitration starts from ptr=0 in IDLE.
  - Every FSM goes to IDLE, with own_j=0 and ptr_j=0.
  - ovalid=0, odata=0, ovch=0, otail=0.
  - grt is forced to 0 for as long as rst_=1.
- Reset in the middle of a packet drops the lock. The remaining flits of that packet must re-request and are treated as a new head flit; upstream flushing is the upstream block's responsibility.
- Simultaneous events:
  - A tail transfer and a new request to the same output: the new request is served the next cycle.
  - ordy[j] falling while BUSY: the grant is suppressed the same cycle and the lock is kept.
- Throughput is 1 flit/cycle/output; all NPORT outputs are concurrent.

## Test plan
- Single-flit routing: NPORT=5. Input 3 sends req=1, port=1, ivalid=1, itail=1, idata=0xA5, ivch=2.
  - Cycle t: grt[3]=5'b00010.
  - Cycle t+1: ovalid[1]=1, odata_1=0xA5, ovch_1=2, otail_1=1.
  - Cycle t+2: ovalid[1]=0.
- Round-robin fairness: inputs 0, 2 and 4 all send continuous single-flit packets to output 2. Grants rotate 0,2,4,0,2,4. After 300 cycles each input has exactly 100 transfers.
- Packet lock: input 1 sends a 4-flit packet to output 0, and input 3 requests output 0 from the packet's second cycle. Output 0 carries all 4 of input 1's flits contiguously. grt[3][0]=0 until the cycle after the tail, when input 3 is granted.
- Backpressure: ordy[4] is held 0 for 3 cycles during a BUSY packet from input 2. grt[2][4]=0 and ovalid[4]=0 for those cycles, the lock is kept, and the packet resumes with no lost or duplicated flits.
- Parallel and illegal ports: NPORT=5 with inputs i→(i+1) mod 5 all active, plus an extra NPORT=8 configuration with port=7 legal and port values driven ≥NPORT for NPORT=5.
  - All 5 outputs are valid in the same cycle.
  - A port value ≥NPORT produces grt=0 and no output activity.
- Reset mid-packet: rst_=1 for 1 cycle after the 2nd of 4 flits. The next cycle shows ovalid=0, grt=0, ptr=0 and IDLE, and a new request from another input is granted immediately.
